// File: rtl/writeback_queue_if.sv
// Bundle between result producers / decode and the writeback queue.
// The queue side uses the slave modport; the producer/decode side uses master.
interface writeback_queue_if #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 mem_valid;
  logic [ADD_WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0]     mem_data;
  logic                 alu_valid;
  logic [ADD_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]     alu_data;
  logic                 push_ready;
  logic                 rf_write_enable;
  logic [ADD_WIDTH-1:0] rf_address;
  logic [WIDTH-1:0]     rf_write_data;
  logic [ADD_WIDTH-1:0] rs1_address;
  logic [ADD_WIDTH-1:0] rs2_address;
  logic                 rs1_pending;
  logic                 rs2_pending;
  logic                 rs1_fwd_valid;
  logic                 rs2_fwd_valid;
  logic [WIDTH-1:0]     rs1_fwd_data;
  logic [WIDTH-1:0]     rs2_fwd_data;
  logic [CW-1:0]        count;
  logic                 overflow;

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    output rs1_address, rs2_address,
    input  push_ready, rf_write_enable, rf_address, rf_write_data,
    input  rs1_pending, rs2_pending, rs1_fwd_valid, rs2_fwd_valid,
    input  rs1_fwd_data, rs2_fwd_data, count, overflow
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    input  rs1_address, rs2_address,
    output push_ready, rf_write_enable, rf_address, rf_write_data,
    output rs1_pending, rs2_pending, rs1_fwd_valid, rs2_fwd_valid,
    output rs1_fwd_data, rs2_fwd_data, count, overflow
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback queue: up to two pushes per cycle, one register-file write per cycle.
// Define WBQ_FORWARD_EN to build the newest-match operand forwarding path.
module writeback_queue #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int DEPTH     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADD_WIDTH-1:0] r_rd   [DEPTH];
  logic [WIDTH-1:0]     r_data [DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;
  logic                 r_rf_we;
  logic [ADD_WIDTH-1:0] r_rf_addr;
  logic [WIDTH-1:0]     r_rf_data;

  logic                 w_pop;
  logic [CW:0]          w_free;
  logic                 w_mem_req, w_alu_req;
  logic                 w_mem_acc, w_alu_acc;
  logic                 w_drop;
  logic [PW-1:0]        w_alu_slot;
  logic [DEPTH-1:0]     w_live;
  logic [DEPTH-1:0]     w_hit1, w_hit2;
  logic                 w_pend1, w_pend2;

  // A pop on this edge frees a slot the pushes may reuse immediately.
  assign w_pop      = (r_count != '0);
  assign w_free     = (CW+1)'(DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
  assign w_mem_req  = bus.mem_valid && (bus.mem_rd != '0);
  assign w_alu_req  = bus.alu_valid && (bus.alu_rd != '0);
  assign w_mem_acc  = w_mem_req && (w_free != '0);
  assign w_alu_acc  = w_alu_req && (w_free > {{CW{1'b0}}, w_mem_acc});
  assign w_drop     = (w_mem_req && !w_mem_acc) || (w_alu_req && !w_alu_acc);
  assign w_alu_slot = r_tail + PW'(w_mem_acc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k]   <= '0;
        r_data[k] <= '0;
      end
    end else begin
      if (w_mem_acc) begin
        r_rd[r_tail]   <= bus.mem_rd;
        r_data[r_tail] <= bus.mem_data;
      end
      if (w_alu_acc) begin
        r_rd[w_alu_slot]   <= bus.alu_rd;
        r_data[w_alu_slot] <= bus.alu_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_mem_acc) + PW'(w_alu_acc);
      r_count <= r_count + CW'(w_mem_acc) + CW'(w_alu_acc) - CW'(w_pop);
      r_rf_we <= w_pop;
      if (w_pop) begin
        r_head    <= r_head + PW'(1);
        r_rf_addr <= r_rd[r_head];
        r_rf_data <= r_data[r_head];
      end
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // Liveness by distance from head; the rf_* output stage is already out of the queue.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PW-1:0] w_off;
    assign w_off      = PW'(gi) - r_head;
    assign w_live[gi] = ({1'b0, w_off} < r_count);
    assign w_hit1[gi] = w_live[gi] && (r_rd[gi] == bus.rs1_address);
    assign w_hit2[gi] = w_live[gi] && (r_rd[gi] == bus.rs2_address);
  end

  assign w_pend1 = (bus.rs1_address != '0) && (|w_hit1);
  assign w_pend2 = (bus.rs2_address != '0) && (|w_hit2);

`ifdef WBQ_FORWARD_EN
  logic [WIDTH-1:0] w_fwd1_data, w_fwd2_data;

  // Walk oldest to newest so the youngest matching entry wins.
  always_comb begin
    w_fwd1_data = '0;
    w_fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hit1[r_head + PW'(k)]) w_fwd1_data = r_data[r_head + PW'(k)];
      if (w_hit2[r_head + PW'(k)]) w_fwd2_data = r_data[r_head + PW'(k)];
    end
  end

  assign bus.rs1_fwd_valid = w_pend1;
  assign bus.rs2_fwd_valid = w_pend2;
  assign bus.rs1_fwd_data  = w_fwd1_data;
  assign bus.rs2_fwd_data  = w_fwd2_data;
`else
  assign bus.rs1_fwd_valid = 1'b0;
  assign bus.rs2_fwd_valid = 1'b0;
  assign bus.rs1_fwd_data  = '0;
  assign bus.rs2_fwd_data  = '0;
`endif

  assign bus.push_ready      = (({1'b0, r_count} + (CW+1)'(2)) <= (CW+1)'(DEPTH));
  assign bus.rf_write_enable = r_rf_we;
  assign bus.rf_address      = r_rf_addr;
  assign bus.rf_write_data   = r_rf_data;
  assign bus.rs1_pending     = w_pend1;
  assign bus.rs2_pending     = w_pend2;
  assign bus.count           = r_count;
  assign bus.overflow        = r_overflow;
endmodule
